// File: rtl/seven_segment_reader.sv
// ============================================================================
// Module   : seven_segment_reader
// Purpose  : Recovers BCD frames from a multiplexed seven-segment display bus.
// Options  : SEVEN_SEG_READER_OVERRUN_EN adds the overrun_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
`ifdef SEVEN_SEG_READER_OVERRUN_EN
  output logic [7:0]            overrun_cnt,
`endif
  input  logic                  out_ready
);

  localparam int          c_cnt_w  = $clog2(STABLE_CYCLES + 1);
  localparam int          c_smp_w  = DIGITS + 7;
  localparam [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [c_smp_w-1:0]   r_prev_sample;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_next;
  logic [4*DIGITS-1:0]  r_shadow_bcd;
  logic [4*DIGITS-1:0]  w_shadow_bcd_next;
  logic [DIGITS-1:0]    r_shadow_err;
  logic [DIGITS-1:0]    w_shadow_err_next;
  logic [DIGITS-1:0]    r_seen;
  logic [DIGITS-1:0]    w_seen_next;

  logic [c_smp_w-1:0]   w_sample;
  logic                 w_onehot;
  logic                 w_same;
  logic                 w_capture;
  logic                 w_full;
  logic                 w_xfer;
  logic [3:0]           w_glyph_bcd;
  logic                 w_glyph_err;

  assign w_sample = {dig_sel, seg};
  assign w_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
  assign w_same   = (w_sample == r_prev_sample) && (r_cnt != '0);

  always_comb begin
    w_glyph_bcd = 4'hF;
    w_glyph_err = 1'b0;
    case (seg)
      7'h7E:   w_glyph_bcd = 4'd0;
      7'h30:   w_glyph_bcd = 4'd1;
      7'h6D:   w_glyph_bcd = 4'd2;
      7'h79:   w_glyph_bcd = 4'd3;
      7'h33:   w_glyph_bcd = 4'd4;
      7'h5B:   w_glyph_bcd = 4'd5;
      7'h5F:   w_glyph_bcd = 4'd6;
      7'h70:   w_glyph_bcd = 4'd7;
      7'h7F:   w_glyph_bcd = 4'd8;
      7'h7B:   w_glyph_bcd = 4'd9;
      default: w_glyph_err = 1'b1;
    endcase
  end

  // A run that is already saturated has been captured; only the reaching edge counts.
  always_comb begin
    w_cnt_next = '0;
    if (w_onehot) begin
      if (w_same)
        w_cnt_next = (r_cnt == c_stable) ? r_cnt : r_cnt + c_cnt_w'(1);
      else
        w_cnt_next = c_cnt_w'(1);
    end
  end

  assign w_capture = w_onehot && (w_cnt_next == c_stable) && !(w_same && (r_cnt == c_stable));

  always_comb begin
    w_shadow_bcd_next = r_shadow_bcd;
    w_shadow_err_next = r_shadow_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_capture && dig_sel[i]) begin
        w_shadow_bcd_next[4*i +: 4] = w_glyph_bcd;
        w_shadow_err_next[i]        = w_glyph_err;
      end
    end
  end

  assign w_seen_next = r_seen | (w_capture ? dig_sel : '0);
  assign w_full      = &w_seen_next;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_COLLECT;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_xfer       = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_full) begin
          w_xfer       = 1'b1;
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (w_full)
            w_xfer = 1'b1;
          else
            w_state_next = ST_COLLECT;
        end
      end
      default: w_state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_sample <= '0;
      r_cnt         <= '0;
      r_shadow_bcd  <= '0;
      r_shadow_err  <= '0;
      r_seen        <= '0;
      out_bcd       <= '0;
      out_err       <= '0;
    end else begin
      r_prev_sample <= w_sample;
      r_cnt         <= w_cnt_next;
      r_shadow_bcd  <= w_shadow_bcd_next;
      r_shadow_err  <= w_shadow_err_next;
      r_seen        <= w_xfer ? '0 : w_seen_next;
      if (w_xfer) begin
        out_bcd <= w_shadow_bcd_next;
        out_err <= w_shadow_err_next;
      end
    end
  end

`ifdef SEVEN_SEG_READER_OVERRUN_EN
  logic w_overrun;
  assign w_overrun = w_capture && (&r_seen) && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst)
      overrun_cnt <= 8'd0;
    else if (w_overrun && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

`default_nettype wire
